// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with write-to-read bypass,
// optional hardwired-zero R0 and a sequenced bulk-clear engine.
module reg_file_2r1w #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam bit Z0 = (ZERO_R0 != 0);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic              wr_acc;

  assign busy      = (state_q == CLEAR);
  assign wr_ack    = wr_en & ~busy;
  // Acked R0 writes are swallowed when R0 is hardwired.
  assign wr_acc    = wr_ack & ~(Z0 && wr_addr == '0);
  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_acc)
          mem_d[wr_addr] = wr_data;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats the bypass; R0 masking beats both.
  always_comb begin
    rd_a_d = mem_q[rd_addr_a];
    if (busy && rd_addr_a == cnt_q)
      rd_a_d = '0;
    else if (wr_acc && wr_addr == rd_addr_a)
      rd_a_d = wr_data;
    if (Z0 && rd_addr_a == '0)
      rd_a_d = '0;
  end

  always_comb begin
    rd_b_d = mem_q[rd_addr_b];
    if (busy && rd_addr_b == cnt_q)
      rd_b_d = '0;
    else if (wr_acc && wr_addr == rd_addr_b)
      rd_b_d = wr_data;
    if (Z0 && rd_addr_b == '0)
      rd_b_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: two DUTs (R0 ordinary / R0 hardwired)
// share stimulus and are checked against an array model.
module tb_reg_file_2r1w;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          clr_req = 1'b0;

  logic          wr_ack, z_wr_ack;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [DW-1:0] z_rd_data_a, z_rd_data_b;
  logic          busy, z_busy;

  always #5 clk = ~clk;

  reg_file_2r1w #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_R0(0)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy)
  );

  reg_file_2r1w #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_R0(1)
  ) dutz (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(z_wr_ack),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
    .clr_req(clr_req), .busy(z_busy)
  );

  typedef struct {
    logic [DW-1:0] a, b, za, zb;
    logic          bsy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int   mem  [NR];
  int   memz [NR];
  bit   m_busy;
  int   m_idx;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int rd_exp(input int addr, input bit z,
                                input bit ack, input int wa,
                                input int wd);
    if (z && addr == 0) return 0;
    if (m_busy && addr == m_idx) return 0;
    if (ack && wa == addr) return wd;
    return z ? memz[addr] : mem[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mem[i]  = 0;
      memz[i] = 0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  task automatic cycle(input bit we, input int wa, input int wd,
                       input int ra, input int rb, input bit cr);
    exp_t e;
    bit   ack;
    @(negedge clk);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = DW'(wd);
    rd_addr_a = AW'(ra);
    rd_addr_b = AW'(rb);
    clr_req   = cr;
    #1;
    ack = we && !m_busy;
    chk("wr_ack", {31'b0, wr_ack}, {31'b0, ack});
    chk("z_wr_ack", {31'b0, z_wr_ack}, {31'b0, ack});
    e.a  = DW'(rd_exp(ra, 1'b0, ack, wa, wd));
    e.b  = DW'(rd_exp(rb, 1'b0, ack, wa, wd));
    e.za = DW'(rd_exp(ra, 1'b1, ack, wa, wd));
    e.zb = DW'(rd_exp(rb, 1'b1, ack, wa, wd));
    if (m_busy) begin
      mem[m_idx]  = 0;
      memz[m_idx] = 0;
      m_idx++;
      if (m_idx == NR) m_busy = 1'b0;
    end else begin
      if (ack) begin
        mem[wa] = wd;
        if (wa != 0) memz[wa] = wd;
      end
      if (cr) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
    e.bsy = m_busy;
    sbq.push_back(e);
  endtask

  task automatic idle(input int ra, input int rb);
    cycle(1'b0, 0, 0, ra, rb, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    wr_en   = 1'b0;
    clr_req = 1'b0;
    #1;
    chk("rst_rd_a", {16'b0, rd_data_a}, 32'h0);
    chk("rst_rd_b", {16'b0, rd_data_b}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_z_rd_a", {16'b0, z_rd_data_a}, 32'h0);
    chk("rst_z_rd_b", {16'b0, z_rd_data_b}, 32'h0);
    chk("rst_z_busy", {31'b0, z_busy}, 32'h0);
    model_reset();
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rd_a", {16'b0, rd_data_a}, {16'b0, e.a});
        chk("rd_b", {16'b0, rd_data_b}, {16'b0, e.b});
        chk("z_rd_a", {16'b0, z_rd_data_a}, {16'b0, e.za});
        chk("z_rd_b", {16'b0, z_rd_data_b}, {16'b0, e.zb});
        chk("busy", {31'b0, busy}, {31'b0, e.bsy});
        chk("z_busy", {31'b0, z_busy}, {31'b0, e.bsy});
      end
    end
  end

  initial begin : driver
    int bcnt;
    model_reset();
    do_reset();

    for (int i = 0; i < NR; i++) idle(i, NR - 1 - i);

    cycle(1'b1, 5, 16'hBEEF, 0, 1, 1'b0);
    idle(5, 5);

    cycle(1'b1, 3, 16'h1234, 3, 5, 1'b0);
    cycle(1'b1, 0, 16'hFFFF, 0, 0, 1'b0);
    idle(0, 3);

    for (int i = 0; i < NR; i++)
      cycle(1'b1, i, 16'h0100 + i, i, 0, 1'b0);
    cycle(1'b0, 0, 0, 7, 8, 1'b1);
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) cycle(1'b1, 7, 16'hAAAA, 7, k % NR, 1'b0);
      else if (k == 6) cycle(1'b0, 0, 0, 1, 2, 1'b1);
      else idle(k % NR, 15 - (k % NR));
      if (busy) bcnt++;
    end
    chk("busy_len", bcnt, 16);
    for (int i = 0; i < NR; i++) idle(i, i);

    for (int i = 0; i < NR; i++)
      cycle(1'b1, i, $urandom_range(0, 16'hFFFF), 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) idle(k, 15 - k);
    do_reset();
    cycle(1'b1, 2, 16'h5A5A, 2, 2, 1'b0);
    idle(2, 2);

    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(0, 1)),
            int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, 16'hFFFF)),
            int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, NR - 1)),
            ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
